// File: rtl/duck_game_ctl_pkg.sv
// Shared constants and types for the Duck Hunt game-flow controller.
// Screen geometry sets the on-screen limits; the speeds and counts are game defaults.
package duck_game_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLY       = 3'd1,
    FALL      = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int HOR_PIXELS  = 1024;
  localparam int VER_PIXELS  = 768;
  localparam int DUCK_WIDTH  = 64;
  localparam int DUCK_HEIGHT = 48;

  localparam int X_MAX   = HOR_PIXELS - DUCK_WIDTH;
  localparam int Y_FLOOR = VER_PIXELS - DUCK_HEIGHT;

  localparam int AMMO_QUANTITY  = 15;
  localparam int H_SPEED        = 10;
  localparam int V_SPEED        = 4;
  localparam int FALL_SPEED     = 8;
  localparam int Y_START        = 200;
  localparam int Y_MIN          = 64;
  localparam int Y_MAX          = 500;
  localparam int RESPAWN_FRAMES = 30;

  // Signed working width for position arithmetic; wide enough that no step can wrap.
  localparam int COORD_W = 12;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/duck_motion.sv
// One-axis position stepper: moves by STEP per enable, and on reaching MIN or MAX
// clamps to that limit and reverses direction (dir = 1 means increasing).
module duck_motion
  import duck_game_ctl_pkg::*;
#(
  parameter int STEP    = 1,
  parameter int MIN     = 0,
  parameter int MAX     = 1,
  parameter int POS_W   = 11,
  parameter int RST_POS = 0,
  parameter bit RST_DIR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [POS_W-1:0] load_value,
  input  logic             load_dir,
  output logic [POS_W-1:0] position,
  output logic             dir
);

  localparam logic signed [COORD_W-1:0] STEP_S = COORD_W'(STEP);
  localparam logic signed [COORD_W-1:0] MIN_S  = COORD_W'(MIN);
  localparam logic signed [COORD_W-1:0] MAX_S  = COORD_W'(MAX);

  logic signed [COORD_W-1:0] cur;
  logic signed [COORD_W-1:0] nxt;
  logic [POS_W-1:0]          pos_next;
  logic                      dir_next;

  always_comb begin
    cur      = COORD_W'(position);
    nxt      = dir ? (cur + STEP_S) : (cur - STEP_S);
    pos_next = POS_W'(nxt);
    dir_next = dir;
    if (dir && (nxt >= MAX_S)) begin
      pos_next = POS_W'(MAX);
      dir_next = 1'b0;
    end else if (!dir && (nxt <= MIN_S)) begin
      pos_next = POS_W'(MIN);
      dir_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= POS_W'(RST_POS);
      dir      <= RST_DIR;
    end else if (load) begin
      position <= load_value;
      dir      <= load_dir;
    end else if (enable) begin
      position <= pos_next;
      dir      <= dir_next;
    end
  end

endmodule

// File: rtl/duck_game_ctl.sv
// Duck Hunt game-flow controller: sequences one duck through fly/fall/respawn,
// tracks ammo and score, and steps the duck once per video frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, duck hidden, waiting for start
// FLY       | duck visible and bouncing; shots are evaluated
// FALL      | duck hit, x frozen, y drops each frame until the floor
// RESPAWN   | duck hidden for RESPAWN_FRAMES frames, or game ends if out of ammo
// GAME_OVER | duck hidden, score held, waiting for start
module duck_game_ctl #(
  parameter int AMMO_QUANTITY  = duck_game_ctl_pkg::AMMO_QUANTITY,
  parameter int H_SPEED        = duck_game_ctl_pkg::H_SPEED,
  parameter int V_SPEED        = duck_game_ctl_pkg::V_SPEED,
  parameter int FALL_SPEED     = duck_game_ctl_pkg::FALL_SPEED,
  parameter int Y_START        = duck_game_ctl_pkg::Y_START,
  parameter int Y_MIN          = duck_game_ctl_pkg::Y_MIN,
  parameter int Y_MAX          = duck_game_ctl_pkg::Y_MAX,
  parameter int RESPAWN_FRAMES = duck_game_ctl_pkg::RESPAWN_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        trigger,
  input  logic        hit,
  output logic [10:0] duck_x,
  output logic [9:0]  duck_y,
  output logic        duck_dir,
  output logic        duck_visible,
  output logic        duck_falling,
  output logic [3:0]  ammo,
  output logic [7:0]  score,
  output logic        game_over
);

  import duck_game_ctl_pkg::*;

  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

  game_state_t        state;
  game_state_t        state_next;
  logic               shot_valid;
  logic               shot_hit;
  logic               init_game;
  logic               fall_tick;
  logic               fall_land;
  logic               respawn_done;
  logic [COORD_W-1:0] y_fall;
  logic               spawn_right;
  logic [CNT_W-1:0]   respawn_cnt;
  logic               move_en;
  logic               x_load;
  logic [10:0]        x_load_value;
  logic               x_load_dir;
  logic               y_load;
  logic [9:0]         y_load_value;
  logic               y_dir_unused;

  assign shot_valid   = (state == FLY) && trigger && (ammo != '0);
  assign shot_hit     = shot_valid && hit;
  assign init_game    = start && ((state == IDLE) || (state == GAME_OVER));
  assign fall_tick    = (state == FALL) && frame_tick;
  assign y_fall       = COORD_W'(duck_y) + COORD_W'(FALL_SPEED);
  assign fall_land    = y_fall >= COORD_W'(Y_FLOOR);
  assign respawn_done = (state == RESPAWN) && (ammo != '0) && frame_tick
                        && (respawn_cnt == CNT_W'(1));

  // A hit freezes the duck at the position the shot was judged against.
  assign move_en = (state == FLY) && frame_tick && !shot_hit;

  assign x_load       = init_game || respawn_done;
  assign x_load_value = (respawn_done && spawn_right) ? 11'(X_MAX) : 11'd0;
  assign x_load_dir   = !(respawn_done && spawn_right);

  assign y_load       = init_game || respawn_done || fall_tick;
  assign y_load_value = fall_tick ? (fall_land ? 10'(Y_FLOOR) : y_fall[9:0]) : 10'(Y_START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = FLY;
      FLY: begin
        if (shot_hit)                       state_next = FALL;
        else if (shot_valid && ammo == 4'd1) state_next = GAME_OVER;
      end
      FALL:      if (frame_tick && fall_land) state_next = RESPAWN;
      RESPAWN: begin
        if (ammo == '0)        state_next = GAME_OVER;
        else if (respawn_done) state_next = FLY;
      end
      GAME_OVER: if (start) state_next = FLY;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    duck_visible = (state == FLY) || (state == FALL);
    duck_falling = (state == FALL);
    game_over    = (state == GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ammo        <= 4'(AMMO_QUANTITY);
      score       <= 8'd0;
      spawn_right <= 1'b1;
      respawn_cnt <= '0;
    end else begin
      if (init_game) begin
        ammo        <= 4'(AMMO_QUANTITY);
        score       <= 8'd0;
        spawn_right <= 1'b1;
      end else begin
        if (shot_valid)   ammo        <= ammo - 4'd1;
        if (shot_hit)     score       <= sat_inc8(score);
        if (respawn_done) spawn_right <= !spawn_right;
      end
      if (fall_tick && fall_land)
        respawn_cnt <= CNT_W'(RESPAWN_FRAMES);
      else if ((state == RESPAWN) && frame_tick && (respawn_cnt != '0))
        respawn_cnt <= respawn_cnt - CNT_W'(1);
    end
  end

  duck_motion #(
    .STEP(H_SPEED), .MIN(0), .MAX(X_MAX), .POS_W(11), .RST_POS(0), .RST_DIR(1'b1)
  ) u_motion_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (move_en),
    .load      (x_load),
    .load_value(x_load_value),
    .load_dir  (x_load_dir),
    .position  (duck_x),
    .dir       (duck_dir)
  );

  // Vertical direction always restarts upward (decreasing y).
  duck_motion #(
    .STEP(V_SPEED), .MIN(Y_MIN), .MAX(Y_MAX), .POS_W(10), .RST_POS(Y_START), .RST_DIR(1'b0)
  ) u_motion_y (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (move_en),
    .load      (y_load),
    .load_value(y_load_value),
    .load_dir  (1'b0),
    .position  (duck_y),
    .dir       (y_dir_unused)
  );

endmodule

// File: tb/tb_duck_game_ctl.sv
// Directed bench for duck_game_ctl: flight bounce, hit/fall/respawn, ammo exhaustion,
// coincident shot and frame tick, and asynchronous reset mid-fall.
module tb_duck_game_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, start, trigger, hit;
  logic [10:0] duck_x;
  logic [9:0]  duck_y;
  logic        duck_dir, duck_visible, duck_falling, game_over;
  logic [3:0]  ammo;
  logic [7:0]  score;

  int n_checks = 0;
  int n_pass   = 0;

  // {start, trigger, hit, frame_tick}
  localparam logic [3:0] V_TICK  = 4'b0001;
  localparam logic [3:0] V_MISS  = 4'b0100;
  localparam logic [3:0] V_HIT   = 4'b0110;
  localparam logic [3:0] V_START = 4'b1000;

  always #5 clk = ~clk;

  duck_game_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .start       (start),
    .trigger     (trigger),
    .hit         (hit),
    .duck_x      (duck_x),
    .duck_y      (duck_y),
    .duck_dir    (duck_dir),
    .duck_visible(duck_visible),
    .duck_falling(duck_falling),
    .ammo        (ammo),
    .score       (score),
    .game_over   (game_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One-cycle pulse: driven on a negedge, seen by one posedge, results read on the next negedge.
  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    {start, trigger, hit, frame_tick} = v;
    @(negedge clk);
    {start, trigger, hit, frame_tick} = 4'b0000;
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(V_TICK);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},    int'(duck_x), 0);
    check({tag, "_y"},    int'(duck_y), 200);
    check({tag, "_dir"},  int'(duck_dir), 1);
    check({tag, "_vis"},  int'(duck_visible), 0);
    check({tag, "_fall"}, int'(duck_falling), 0);
    check({tag, "_ammo"}, int'(ammo), 15);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_go"},   int'(game_over), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    {start, trigger, hit, frame_tick} = 4'b0000;
    #3 rst_n = 1'b0;
    #4 check_reset_values("rst");
    @(negedge clk) rst_n = 1'b1;

    // Start, then fly right to the edge; vertical bounce at the ceiling on the way.
    drive(V_START);
    check("start_vis", int'(duck_visible), 1);
    check("start_x", int'(duck_x), 0);
    for (int i = 1; i <= 96; i++) begin
      ticks(1);
      if (i == 34) check("y_ceiling", int'(duck_y), 64);
      if (i == 35) check("y_rebound", int'(duck_y), 68);
    end
    check("x_edge", int'(duck_x), 960);
    check("dir_flip", int'(duck_dir), 0);
    check("y_96", int'(duck_y), 312);
    ticks(1);
    check("x_back", int'(duck_x), 950);
    check("y_97", int'(duck_y), 316);

    // Hit, fall to the floor, respawn on the right side.
    drive(V_HIT);
    check("hit_ammo", int'(ammo), 14);
    check("hit_score", int'(score), 1);
    check("hit_falling", int'(duck_falling), 1);
    ticks(50);
    check("fall_y50", int'(duck_y), 716);
    check("fall_x_frozen", int'(duck_x), 950);
    ticks(1);
    check("floor_y", int'(duck_y), 720);
    check("respawn_vis", int'(duck_visible), 0);
    check("respawn_fall", int'(duck_falling), 0);
    ticks(29);
    check("respawn_29_vis", int'(duck_visible), 0);
    ticks(1);
    check("spawn2_vis", int'(duck_visible), 1);
    check("spawn2_x", int'(duck_x), 960);
    check("spawn2_dir", int'(duck_dir), 0);
    check("spawn2_y", int'(duck_y), 200);

    // Shot coincident with a frame tick at x=500: position update is dropped.
    ticks(46);
    check("pre_coinc_x", int'(duck_x), 500);
    check("pre_coinc_y", int'(duck_y), 112);
    drive(V_HIT | V_TICK);
    check("coinc_x", int'(duck_x), 500);
    check("coinc_y", int'(duck_y), 112);
    check("coinc_fall", int'(duck_falling), 1);
    check("coinc_score", int'(score), 2);
    drive(V_MISS);
    check("fall_trig_ammo", int'(ammo), 13);
    ticks(76);
    check("floor2_y", int'(duck_y), 720);
    check("floor2_vis", int'(duck_visible), 0);
    ticks(30);
    check("spawn3_x", int'(duck_x), 0);
    check("spawn3_dir", int'(duck_dir), 1);

    // start while flying is ignored.
    ticks(3);
    drive(V_START);
    check("start_ign_x", int'(duck_x), 30);
    check("start_ign_ammo", int'(ammo), 13);
    check("start_ign_score", int'(score), 2);

    // Third hit, then asynchronous reset in the middle of the fall.
    drive(V_HIT);
    check("hit3_score", int'(score), 3);
    check("hit3_fall", int'(duck_falling), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk) rst_n = 1'b1;
    ticks(2);
    drive(V_MISS);
    check_reset_values("post_rst");

    // Run out of ammo on misses.
    drive(V_START);
    check("go_start_vis", int'(duck_visible), 1);
    for (int i = 1; i <= 15; i++) begin
      drive(V_MISS);
      if (i == 14) begin
        check("ammo_14", int'(ammo), 1);
        check("go_14", int'(game_over), 0);
      end
    end
    check("ammo_0", int'(ammo), 0);
    check("go_15", int'(game_over), 1);
    check("go_vis", int'(duck_visible), 0);
    drive(V_MISS);
    check("go_extra_ammo", int'(ammo), 0);
    drive(V_START);
    check("restart_ammo", int'(ammo), 15);
    check("restart_score", int'(score), 0);
    check("restart_go", int'(game_over), 0);
    check("restart_vis", int'(duck_visible), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
